// File: rtl/round_shift_sched.sv
// Shared round-half-up right-shift unit, round-robin over N requesters; ROUND_RNE_EN selects ties-to-even.
// Latency 2 cycles accept->out_valid, 1 result/cycle.
// Backpressure: out_ready=0 stalls S2 then S1; req_ready drops to 0 once both stages hold data.
module round_shift_sched #(
    parameter int N     = 4,
    parameter int IN_W  = 5,
    parameter int SH_W  = 4,
    parameter int OUT_W = 8,
    parameter int ID_W  = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic [N-1:0]        req_valid,
    output logic [N-1:0]        req_ready,
    input  logic [N*IN_W-1:0]   req_data,
    input  logic [N*SH_W-1:0]   req_shift,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic [ID_W-1:0]     out_id,
    output logic                busy
);
    localparam int SUM_W = IN_W + 1;

    logic [ID_W-1:0]  r_ptr;
    logic             r_s1_vld;
    logic [IN_W-1:0]  r_s1_x;
    logic [SH_W-1:0]  r_s1_sh;
    logic [ID_W-1:0]  r_s1_id;
    logic             r_s2_vld;
    logic [OUT_W-1:0] r_s2_dat;
    logic [ID_W-1:0]  r_s2_id;

    logic             w_s2_load;
    logic             w_s1_load;
    logic             w_gnt_vld;
    logic [ID_W-1:0]  w_gnt_id;
    logic             w_acc;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [SUM_W-1:0] w_x;
    logic [SUM_W-1:0] w_half;
    logic [SUM_W-1:0] w_rnd;
    logic [OUT_W-1:0] w_res;
`ifdef ROUND_RNE_EN
    logic [SUM_W-1:0] w_mask;
    logic [SUM_W-1:0] w_trunc;
    logic             w_tie;
`endif

    assign w_s2_load = !r_s2_vld || out_ready;
    assign w_s1_load = !r_s1_vld || w_s2_load;
    // rst_b gating keeps req_ready low for the whole reset window, not just after the first edge.
    assign w_acc     = rst_b && w_s1_load && w_gnt_vld;
    assign w_ptr_nxt = (w_gnt_id == ID_W'(N - 1)) ? '0 : w_gnt_id + 1'b1;

    always_comb begin : arb
        int idx;
        idx       = 0;
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(r_ptr) + k) % N;
            if (!w_gnt_vld && req_valid[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (w_acc) req_ready[w_gnt_id] = 1'b1;
    end

    // Sum is IN_W+1 wide so x near full scale keeps its rounding carry.
    always_comb begin
        w_x    = {1'b0, r_s1_x};
        w_half = '0;
        w_rnd  = '0;
        w_res  = '0;
`ifdef ROUND_RNE_EN
        w_mask  = '0;
        w_trunc = '0;
        w_tie   = 1'b0;
`endif
        if (r_s1_sh == '0) begin
            w_res = OUT_W'(w_x);
        end else if (int'(r_s1_sh) <= IN_W) begin
            w_half = SUM_W'(1) << (r_s1_sh - 1'b1);
            w_rnd  = (w_x + w_half) >> r_s1_sh;
`ifdef ROUND_RNE_EN
            w_mask  = (w_half << 1) - 1'b1;
            w_trunc = w_x >> r_s1_sh;
            w_tie   = (w_x & w_mask) == w_half;
            if (w_tie && !w_trunc[0]) w_rnd = w_trunc;
`endif
            w_res = OUT_W'(w_rnd);
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_ptr    <= '0;
            r_s1_vld <= 1'b0;
            r_s1_x   <= '0;
            r_s1_sh  <= '0;
            r_s1_id  <= '0;
            r_s2_vld <= 1'b0;
            r_s2_dat <= '0;
            r_s2_id  <= '0;
        end else begin
            if (w_acc) r_ptr <= w_ptr_nxt;
            if (w_s1_load) begin
                r_s1_vld <= w_acc;
                if (w_acc) begin
                    r_s1_x  <= req_data[int'(w_gnt_id)*IN_W +: IN_W];
                    r_s1_sh <= req_shift[int'(w_gnt_id)*SH_W +: SH_W];
                    r_s1_id <= w_gnt_id;
                end
            end
            if (w_s2_load) begin
                r_s2_vld <= r_s1_vld;
                if (r_s1_vld) begin
                    r_s2_dat <= w_res;
                    r_s2_id  <= r_s1_id;
                end
            end
        end
    end

    assign out_valid = r_s2_vld;
    assign out_data  = r_s2_dat;
    assign out_id    = r_s2_id;
    assign busy      = r_s1_vld | r_s2_vld;
endmodule

// File: tb/tb_round_shift_sched.sv
// Bench for round_shift_sched: vector table, rotation, stall, pointer and reset sequences with a result scoreboard.
module tb_round_shift_sched;
    localparam int N = 4, IN_W = 5, SH_W = 4, OUT_W = 8, ID_W = 2;

    logic                clk = 1'b0;
    logic                rst_b;
    logic [N-1:0]        req_valid;
    logic [N-1:0]        req_ready;
    logic [N*IN_W-1:0]   req_data;
    logic [N*SH_W-1:0]   req_shift;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_data;
    logic [ID_W-1:0]     out_id;
    logic                busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed { logic [ID_W-1:0] id; logic [OUT_W-1:0] dat; } exp_t;
    exp_t sb_q[$];

    typedef struct { int r; int x; int s; int exp; } vec_t;
    vec_t vecs[10];

`ifdef ROUND_RNE_EN
    localparam int TIE10 = 2, TIE16 = 0;
`else
    localparam int TIE10 = 3, TIE16 = 1;
`endif

    round_shift_sched #(.N(N), .IN_W(IN_W), .SH_W(SH_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_b(rst_b),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_shift(req_shift),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_id(out_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] model(input int x, input int s);
        int q, r, h;
        if (s == 0) return OUT_W'(x);
        if (s > IN_W) return '0;
        q = x >> s;
        r = x - (q << s);
        h = 1 << (s - 1);
        if (r > h) return OUT_W'(q + 1);
        if (r < h) return OUT_W'(q);
`ifdef ROUND_RNE_EN
        return (q % 2 == 1) ? OUT_W'(q + 1) : OUT_W'(q);
`else
        return OUT_W'(q + 1);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshakes are stable between the negedge and the next posedge, so they are sampled here.
    always @(negedge clk) begin
        if (!rst_b) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_result", 32'(sb_q.size()), 1);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_data", out_data, e.dat);
                    chk("sb_id", out_id, e.id);
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_t e;
                    e.id  = ID_W'(i);
                    e.dat = model(int'(req_data[i*IN_W +: IN_W]), int'(req_shift[i*SH_W +: SH_W]));
                    sb_q.push_back(e);
                end
            end
        end
    end

    initial begin
        int acc;
        logic have;
        logic [OUT_W-1:0] first_dat;

        vecs[0] = '{0,  0, 0, 0};
        vecs[1] = '{1,  3, 1, 2};
        vecs[2] = '{2, 12, 3, 2};
        vecs[3] = '{3, 22, 2, 6};
        vecs[4] = '{0,  9, 2, 2};
        vecs[5] = '{1, 31, 9, 0};
        vecs[6] = '{2, 10, 2, TIE10};
        vecs[7] = '{3, 31, 1, 16};
        vecs[8] = '{0, 31, 5, 1};
        vecs[9] = '{1, 16, 5, TIE16};

        rst_b     = 1'b0;
        req_valid = '1;
        req_data  = '0;
        req_shift = '0;
        out_ready = 1'b1;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_id", out_id, 0);
        chk("rst_req_ready", req_ready, 0);
        tick();
        tick();
        req_valid = '0;
        rst_b     = 1'b1;
        tick();

        foreach (vecs[v]) begin
            req_data  = '0;
            req_shift = '0;
            req_data[vecs[v].r*IN_W +: IN_W]  = IN_W'(vecs[v].x);
            req_shift[vecs[v].r*SH_W +: SH_W] = SH_W'(vecs[v].s);
            req_valid = N'(1) << vecs[v].r;
            #1;
            chk("vec_ready", req_ready, 32'(1) << vecs[v].r);
            tick();
            req_valid = '0;
            chk("vec_lat_t1", out_valid, 0);
            tick();
            chk("vec_lat_t2", out_valid, 1);
            chk("vec_data", out_data, vecs[v].exp);
            chk("vec_id", out_id, vecs[v].r);
            tick();
        end

        rst_b = 1'b0;
        tick();
        rst_b     = 1'b1;
        req_data  = {5'd7, 5'd20, 5'd13, 5'd31};
        req_shift = {4'd1, 4'd0, 4'd3, 4'd2};
        req_valid = '1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("rot_grant", req_ready, 32'(1) << (k % 4));
            if (k >= 2) begin
                chk("rot_out_valid", out_valid, 1);
                chk("rot_out_id", out_id, (k - 2) % 4);
            end
            tick();
        end
        req_valid = '0;
        repeat (3) tick();

        out_ready = 1'b0;
        req_valid = '1;
        acc       = 0;
        have      = 1'b0;
        first_dat = '0;
        for (int c = 0; c < 5; c++) begin
            #1;
            acc += $countones(req_ready);
            if (out_valid) begin
                if (!have) begin
                    first_dat = out_data;
                    have      = 1'b1;
                end else begin
                    chk("stall_data_stable", out_data, first_dat);
                end
            end
            tick();
        end
        #1;
        chk("stall_accepts", acc, 2);
        chk("stall_ready_zero", req_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        out_ready = 1'b1;
        req_valid = '0;
        repeat (4) tick();
        chk("stall_drained", 32'(sb_q.size()), 0);
        chk("stall_idle", busy, 0);

        req_valid = 4'b0100;
        #1;
        chk("ptr_set_grant", req_ready, 4'b0100);
        tick();
        #1;
        chk("ptr3_single_grant", req_ready, 4'b0100);
        tick();
        req_valid = '1;
        #1;
        chk("ptr_after_single", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        repeat (4) tick();

        out_ready = 1'b0;
        req_valid = '1;
        tick();
        tick();
        #1;
        chk("full_busy", busy, 1);
        chk("full_out_valid", out_valid, 1);
        rst_b = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_req_ready", req_ready, 0);
        tick();
        tick();
        rst_b = 1'b1;
        #1;
        chk("postrst_grant", req_ready, 4'b0001);
        out_ready = 1'b1;
        tick();
        req_valid = '0;
        repeat (4) tick();
        chk("postrst_drained", 32'(sb_q.size()), 0);
        chk("postrst_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
